// File: rtl/cdc_xfer_arbiter.sv
// Source-domain arbiter sharing one req/ack CDC channel among NUM_REQ requesters.
// Round-robin grant, one transfer in flight, per-requester done/err pulses and ack timeout.
module cdc_xfer_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic                      src_clk,
  input  logic                      src_rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        done,
  output logic [NUM_REQ-1:0]        err,
  output logic                      busy,
  output logic                      xfer_req,
  output logic [DATA_W-1:0]         xfer_data,
  output logic [ID_W-1:0]           xfer_id,
  input  logic                      ack_sync
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_REQ_HI  = 3'd2,
    ST_REQ_LO  = 3'd3,
    ST_FIN     = 3'd4,
    ST_RECOVER = 3'd5
  } state_t;

  localparam int                 CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(TIMEOUT);
  localparam logic [ID_W-1:0]    LAST_ID = ID_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT = {{(NUM_REQ-1){1'b0}}, 1'b1};

  state_t              state_r, state_s;
  logic [ID_W-1:0]     ptr_r, ptr_s, next_ptr_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic                grant_any_s, hi_any_s;
  logic [ID_W-1:0]     grant_idx_s, hi_idx_s, lo_idx_s;
  logic [DATA_W-1:0]   grant_data_s;
  logic [NUM_REQ-1:0]  done_s, err_s;
  logic                busy_s, xfer_req_s;
  logic [DATA_W-1:0]   xfer_data_s;
  logic [ID_W-1:0]     xfer_id_s;

  // Circular priority scan: lowest set index at/above the pointer wins, else lowest overall.
  always_comb begin
    hi_any_s    = 1'b0;
    hi_idx_s    = {ID_W{1'b0}};
    grant_any_s = 1'b0;
    lo_idx_s    = {ID_W{1'b0}};
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req[j] && (ID_W'(j) >= ptr_r)) begin
        hi_any_s = 1'b1;
        hi_idx_s = ID_W'(j);
      end else begin
        hi_any_s = hi_any_s;
      end
      if (req[j]) begin
        grant_any_s = 1'b1;
        lo_idx_s    = ID_W'(j);
      end else begin
        grant_any_s = grant_any_s;
      end
    end
    grant_idx_s = hi_any_s ? hi_idx_s : lo_idx_s;
  end

  // Payload mux for the winning requester.
  always_comb begin
    grant_data_s = {DATA_W{1'b0}};
    for (int j = 0; j < NUM_REQ; j++) begin
      if (ID_W'(j) == grant_idx_s) begin
        grant_data_s = req_data[j*DATA_W +: DATA_W];
      end else begin
        grant_data_s = grant_data_s;
      end
    end
  end

  assign next_ptr_s = (xfer_id == LAST_ID) ? {ID_W{1'b0}} : xfer_id + {{(ID_W-1){1'b0}}, 1'b1};

  // Next-state logic and next values of every registered output.
  always_comb begin
    state_s     = state_r;
    ptr_s       = ptr_r;
    cnt_s       = cnt_r;
    xfer_data_s = xfer_data;
    xfer_id_s   = xfer_id;
    case (state_r)
      ST_IDLE: begin
        // A lingering ack from an aborted transfer must drain before a new grant.
        if (!ack_sync && grant_any_s) begin
          state_s     = ST_SETUP;
          xfer_data_s = grant_data_s;
          xfer_id_s   = grant_idx_s;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_s = ST_REQ_HI;
        cnt_s   = {CNT_W{1'b0}};
      end
      ST_REQ_HI: begin
        if (ack_sync) begin
          state_s = ST_REQ_LO;
          cnt_s   = {CNT_W{1'b0}};
        end else if ((TIMEOUT != 0) && (cnt_r == CNT_MAX)) begin
          state_s = ST_RECOVER;
        end else begin
          cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_REQ_LO: begin
        if (!ack_sync) begin
          state_s = ST_FIN;
        end else if ((TIMEOUT != 0) && (cnt_r == CNT_MAX)) begin
          state_s = ST_RECOVER;
        end else begin
          cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_FIN: begin
        state_s = ST_IDLE;
        ptr_s   = next_ptr_s;
      end
      ST_RECOVER: begin
        if (!ack_sync) begin
          state_s = ST_IDLE;
          ptr_s   = next_ptr_s;
        end else begin
          state_s = ST_RECOVER;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    busy_s     = (state_s != ST_IDLE);
    xfer_req_s = (state_s == ST_REQ_HI);
    done_s     = (state_s == ST_FIN) ? (ONE_HOT << xfer_id) : {NUM_REQ{1'b0}};
    err_s      = ((state_s == ST_RECOVER) && (state_r != ST_RECOVER)) ?
                 (ONE_HOT << xfer_id) : {NUM_REQ{1'b0}};
  end

  // State, pointer, counter and output registers.
  always_ff @(posedge src_clk) begin
    if (src_rst) begin
      state_r   <= ST_IDLE;
      ptr_r     <= {ID_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      done      <= {NUM_REQ{1'b0}};
      err       <= {NUM_REQ{1'b0}};
      busy      <= 1'b0;
      xfer_req  <= 1'b0;
      xfer_data <= {DATA_W{1'b0}};
      xfer_id   <= {ID_W{1'b0}};
    end else begin
      state_r   <= state_s;
      ptr_r     <= ptr_s;
      cnt_r     <= cnt_s;
      done      <= done_s;
      err       <= err_s;
      busy      <= busy_s;
      xfer_req  <= xfer_req_s;
      xfer_data <= xfer_data_s;
      xfer_id   <= xfer_id_s;
    end
  end

endmodule

// File: tb/tb_cdc_xfer_arbiter.sv
// Directed self-checking bench for cdc_xfer_arbiter (TIMEOUT=8 instance).
module tb_cdc_xfer_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = 8;

  logic                      src_clk = 1'b0;
  logic                      src_rst;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        done;
  logic [NUM_REQ-1:0]        err;
  logic                      busy;
  logic                      xfer_req;
  logic [DATA_W-1:0]         xfer_data;
  logic [ID_W-1:0]           xfer_id;
  logic                      ack_sync;

  logic [DATA_W-1:0] data_tab [NUM_REQ];
  int n_checks = 0;
  int n_errors = 0;

  always #5 src_clk = ~src_clk;

  assign req_data = {data_tab[3], data_tab[2], data_tab[1], data_tab[0]};

  cdc_xfer_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .src_clk  (src_clk),
    .src_rst  (src_rst),
    .req      (req),
    .req_data (req_data),
    .done     (done),
    .err      (err),
    .busy     (busy),
    .xfer_req (xfer_req),
    .xfer_data(xfer_data),
    .xfer_id  (xfer_id),
    .ack_sync (ack_sync)
  );

  task automatic step();
    @(posedge src_clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic wait_req_hi();
    int n;
    n = 0;
    while (xfer_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check_val("xfer_req_rise", xfer_req, 1'b1);
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_done"},      done,      4'b0000);
    check_val({tag, "_err"},       err,       4'b0000);
    check_val({tag, "_busy"},      busy,      1'b0);
    check_val({tag, "_xfer_req"},  xfer_req,  1'b0);
    check_val({tag, "_xfer_data"}, xfer_data, 32'h0000_0000);
    check_val({tag, "_xfer_id"},   xfer_id,   2'd0);
  endtask

  // One complete handshake with an immediate responder; next_req is applied in the FIN cycle.
  task automatic serve(input int id, input logic [3:0] next_req);
    logic [3:0] oh;
    oh = 4'b0001 << id;
    wait_req_hi();
    check_val("serve_id",   xfer_id,   id);
    check_val("serve_data", xfer_data, data_tab[id]);
    ack_sync = 1'b1;
    step();
    check_val("serve_req_lo",  xfer_req, 1'b0);
    check_val("serve_no_done", done,     4'b0000);
    ack_sync = 1'b0;
    step();
    check_val("serve_done",   done, oh);
    check_val("serve_no_err", err,  4'b0000);
    req = next_req;
    step();
    check_val("serve_done_clr", done, 4'b0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    data_tab[0] = 32'hA0A0_1111;
    data_tab[1] = 32'hDEAD_BEEF;
    data_tab[2] = 32'hC2C2_2222;
    data_tab[3] = 32'h3333_F00D;
    src_rst  = 1'b1;
    req      = 4'b0000;
    ack_sync = 1'b0;
    step();
    step();
    check_reset_vals("rst");
    src_rst = 1'b0;
    step();

    // Test 1: single request, exact latency with a 3-cycle responder.
    req = 4'b0010;
    step();
    check_val("t1_id_c1",   xfer_id,   2'd1);
    check_val("t1_data_c1", xfer_data, 32'hDEAD_BEEF);
    check_val("t1_busy_c1", busy,      1'b1);
    check_val("t1_req_c1",  xfer_req,  1'b0);
    step();
    check_val("t1_req_c2", xfer_req, 1'b1);
    step();
    step();
    check_val("t1_req_c4", xfer_req, 1'b1);
    step();
    ack_sync = 1'b1;
    step();
    check_val("t1_req_c6",  xfer_req, 1'b0);
    check_val("t1_done_c6", done,     4'b0000);
    step();
    step();
    ack_sync = 1'b0;
    step();
    check_val("t1_done_c9", done, 4'b0010);
    check_val("t1_busy_c9", busy, 1'b1);
    req = 4'b0000;
    step();
    check_val("t1_done_c10", done, 4'b0000);
    check_val("t1_busy_c10", busy, 1'b0);

    // Test 2: all requesters held, round-robin from pointer 0.
    src_rst = 1'b1;
    step();
    src_rst = 1'b0;
    req = 4'b1111;
    serve(0, 4'b1111);
    serve(1, 4'b1111);
    serve(2, 4'b1111);
    serve(3, 4'b1111);
    serve(0, 4'b0000);
    check_val("t2_idle", busy, 1'b0);

    // Test 3: pointer at 2 after granting 1, then 0 and 1 both requesting.
    req = 4'b0010;
    serve(1, 4'b0011);
    serve(0, 4'b0010);
    serve(1, 4'b0000);

    // Test 4: no ack ever, timeout after TIMEOUT waiting cycles.
    req = 4'b0100;
    wait_req_hi();
    check_val("t4_id", xfer_id, 2'd2);
    for (int i = 1; i <= TIMEOUT; i++) begin
      step();
      check_val("t4_wait_req", xfer_req, 1'b1);
      check_val("t4_wait_err", err,      4'b0000);
    end
    step();
    check_val("t4_err",     err,      4'b0100);
    check_val("t4_req_lo",  xfer_req, 1'b0);
    check_val("t4_no_done", done,     4'b0000);
    check_val("t4_busy",    busy,     1'b1);
    req = 4'b0000;
    step();
    check_val("t4_err_clr", err,  4'b0000);
    check_val("t4_idle",    busy, 1'b0);
    req = 4'b0001;
    serve(0, 4'b0000);

    // Test 6: ack arrives on the cycle the count reaches TIMEOUT.
    req = 4'b1000;
    wait_req_hi();
    check_val("t6_id", xfer_id, 2'd3);
    for (int i = 1; i <= TIMEOUT; i++) begin
      step();
    end
    ack_sync = 1'b1;
    step();
    check_val("t6_req_lo", xfer_req, 1'b0);
    check_val("t6_no_err", err,      4'b0000);
    ack_sync = 1'b0;
    step();
    check_val("t6_done",    done, 4'b1000);
    check_val("t6_no_err2", err,  4'b0000);
    req = 4'b0000;
    step();

    // Test 5: reset in REQ_LO while ack stays high for 5 more cycles.
    req = 4'b1000;
    wait_req_hi();
    ack_sync = 1'b1;
    step();
    check_val("t5_in_req_lo", xfer_req, 1'b0);
    src_rst = 1'b1;
    step();
    src_rst = 1'b0;
    check_reset_vals("t5_rst");
    for (int i = 0; i < 4; i++) begin
      step();
      check_val("t5_blocked_busy", busy,     1'b0);
      check_val("t5_blocked_req",  xfer_req, 1'b0);
    end
    ack_sync = 1'b0;
    serve(3, 4'b0000);
    check_val("t5_final_idle", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
